// File: rtl/mmio_timer_pkg.sv
// Shared types, register offsets and byte-merge helper for the memory-mapped machine timer.
package mmio_timer_pkg;

  typedef enum logic {TIMER_IDLE, TIMER_BUSY} timerState_;

  localparam logic [4:0] TIMER_MTIME_LO    = 5'h00;
  localparam logic [4:0] TIMER_MTIME_HI    = 5'h04;
  localparam logic [4:0] TIMER_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] TIMER_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] TIMER_MSIP        = 5'h10;
  localparam int         TIMER_WINDOW_BYTES = 32;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                              input logic [31:0] data,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = data[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/mmio_prescaler.sv
// Divides the core clock down to one mtime tick every PRESCALE clocks (PRESCALE 1..65535).
module mmio_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  logic [15:0] count;

  assign tick = (count == 16'(PRESCALE - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      count <= '0;
    else if (tick)
      count <= '0;
    else
      count <= count + 16'd1;
  end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped machine timer (mtime/mtimecmp/msip) on the Memory-stage data bus.
// Define MMIO_TIMER_SNAPSHOT_EN for a tear-free 64-bit mtime read through a shadow of mtime[63:32].
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          PRESCALE  = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] storeData,
  input  logic [3:0]  byteEnable,
  input  logic        storeValid,
  input  logic        loadValid,
  output logic [31:0] loadData,
  output logic        loadDataValid,
  output logic        storeComplete,
  output logic        interrupt
);

  timerState_  state;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        msip;
  logic        tick;
  logic [31:0] offset;
  logic        hit;
  logic        aligned;
  logic        accept;
  logic        wr;
  logic        wr_mtime_lo;
  logic        wr_mtime_hi;
  logic [31:0] rdata;
  logic [31:0] mtime_hi_view;

  mmio_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  assign offset  = address - BASE_ADDR;
  assign hit     = (offset < 32'(TIMER_WINDOW_BYTES));
  assign aligned = (address[1:0] == 2'b00);
  assign accept  = (state == TIMER_IDLE) && hit && (loadValid || storeValid);
  assign wr      = accept && storeValid;
  // An mtime write with no enabled bytes leaves the counter free-running.
  assign wr_mtime_lo = wr && aligned && (offset[4:0] == TIMER_MTIME_LO) && (byteEnable != 4'b0);
  assign wr_mtime_hi = wr && aligned && (offset[4:0] == TIMER_MTIME_HI) && (byteEnable != 4'b0);

`ifdef MMIO_TIMER_SNAPSHOT_EN
  logic [31:0] shadow;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      shadow <= '0;
    else if (accept && !storeValid && aligned && offset[4:0] == TIMER_MTIME_LO)
      shadow <= mtime[63:32];
  end

  assign mtime_hi_view = shadow;
`else
  assign mtime_hi_view = mtime[63:32];
`endif

  always_comb begin
    rdata = '0;
    if (aligned) begin
      case (offset[4:0])
        TIMER_MTIME_LO:    rdata = mtime[31:0];
        TIMER_MTIME_HI:    rdata = mtime_hi_view;
        TIMER_MTIMECMP_LO: rdata = mtimecmp[31:0];
        TIMER_MTIMECMP_HI: rdata = mtimecmp[63:32];
        TIMER_MSIP:        rdata = {31'b0, msip};
        default:           rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= TIMER_IDLE;
      mtime         <= '0;
      mtimecmp      <= '1;
      msip          <= 1'b0;
      loadData      <= '0;
      loadDataValid <= 1'b0;
      storeComplete <= 1'b0;
      interrupt     <= 1'b0;
    end else begin
      interrupt <= (mtime >= mtimecmp) | msip;

      // A software write to either mtime half takes priority over the tick.
      if (wr_mtime_lo)
        mtime[31:0] <= merge_bytes(mtime[31:0], storeData, byteEnable);
      else if (wr_mtime_hi)
        mtime[63:32] <= merge_bytes(mtime[63:32], storeData, byteEnable);
      else if (tick)
        mtime <= mtime + 64'd1;

      if (wr && aligned && offset[4:0] == TIMER_MTIMECMP_LO)
        mtimecmp[31:0] <= merge_bytes(mtimecmp[31:0], storeData, byteEnable);
      if (wr && aligned && offset[4:0] == TIMER_MTIMECMP_HI)
        mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], storeData, byteEnable);
      if (wr && aligned && offset[4:0] == TIMER_MSIP && byteEnable[0])
        msip <= storeData[0];

      case (state)
        TIMER_IDLE: begin
          loadDataValid <= 1'b0;
          storeComplete <= 1'b0;
          if (accept) begin
            state <= TIMER_BUSY;
            if (storeValid) begin
              storeComplete <= 1'b1;
            end else begin
              loadData      <= rdata;
              loadDataValid <= 1'b1;
            end
          end
        end
        default: begin
          state         <= TIMER_IDLE;
          loadDataValid <= 1'b0;
          storeComplete <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// Scoreboard bench for mmio_timer: stimulus pushes expected bus responses, a monitor pops and compares.
module tb_mmio_timer;
  localparam logic [31:0] BASE = 32'h0200_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic [31:0] storeData;
  logic [3:0]  byteEnable;
  logic        storeValid;
  logic        loadValid;
  logic [31:0] loadData;
  logic        loadDataValid;
  logic        storeComplete;
  logic        interrupt;

  mmio_timer #(.BASE_ADDR(BASE), .PRESCALE(1)) dut (
    .clock         (clock),
    .reset         (reset),
    .address       (address),
    .storeData     (storeData),
    .byteEnable    (byteEnable),
    .storeValid    (storeValid),
    .loadValid     (loadValid),
    .loadData      (loadData),
    .loadDataValid (loadDataValid),
    .storeComplete (storeComplete),
    .interrupt     (interrupt)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          tag;
    bit          is_store;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   ntag  = 0;
  int   edges = 0;

  // Reference timer state: mtime equals v0 + (edges - t0) while no write intervenes.
  logic [63:0] v0;
  int          t0;
  logic [63:0] cmp_m;
  logic        msip_m;
  logic [31:0] shadow_m;

  function automatic logic [63:0] mt(input int e);
    return v0 + 64'(e - t0);
  endfunction

  function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] data,
                                         input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = data[8*i +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end else begin
      $display("check %s ok: %h", name, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    edges++;
    @(negedge clock);
  endtask

  task automatic model_reset();
    v0 = '0; t0 = edges; cmp_m = '1; msip_m = 1'b0; shadow_m = '0;
  endtask

  // Drives one request for the capture edge only; caller spends the BUSY cycle.
  task automatic issue(input logic [31:0] off, input logic [31:0] data, input logic [3:0] be,
                       input logic st, input logic ld);
    logic [63:0] cur;
    logic [31:0] rd;
    exp_t        e;
    cur = mt(edges);
    if (off < 32 && (st || ld)) begin
      rd = '0;
      if (!st) begin
        case (off)
          32'h00: begin
            rd = cur[31:0];
`ifdef MMIO_TIMER_SNAPSHOT_EN
            shadow_m = cur[63:32];
`endif
          end
`ifdef MMIO_TIMER_SNAPSHOT_EN
          32'h04: rd = shadow_m;
`else
          32'h04: rd = cur[63:32];
`endif
          32'h08: rd = cmp_m[31:0];
          32'h0C: rd = cmp_m[63:32];
          32'h10: rd = {31'b0, msip_m};
          default: rd = '0;
        endcase
      end
      e.tag = ntag; e.is_store = st; e.data = rd;
      ntag++;
      sb.push_back(e);
    end
    address = BASE + off; storeData = data; byteEnable = be; storeValid = st; loadValid = ld;
    tick();
    address = '0; storeData = '0; byteEnable = '0; storeValid = 1'b0; loadValid = 1'b0;
    if (off < 32 && st) begin
      case (off)
        32'h00: if (be != 4'b0) begin v0 = {cur[63:32], bmerge(cur[31:0], data, be)}; t0 = edges; end
        32'h04: if (be != 4'b0) begin v0 = {bmerge(cur[63:32], data, be), cur[31:0]}; t0 = edges; end
        32'h08: cmp_m[31:0]  = bmerge(cmp_m[31:0], data, be);
        32'h0C: cmp_m[63:32] = bmerge(cmp_m[63:32], data, be);
        32'h10: if (be[0]) msip_m = data[0];
        default: ;
      endcase
    end
  endtask

  task automatic xact(input logic [31:0] off, input logic [31:0] data, input logic [3:0] be,
                      input logic st, input logic ld);
    issue(off, data, be, st, ld);
    tick();
  endtask

  // Monitor: every response pops one expectation.
  always @(negedge clock) begin
    exp_t e;
    bit   ok;
    if (loadDataValid || storeComplete) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_response: got ld=%b st=%b data=%h want none",
                 loadDataValid, storeComplete, loadData);
      end else begin
        e = sb.pop_front();
        if (e.is_store) ok = storeComplete && !loadDataValid;
        else            ok = loadDataValid && !storeComplete && (loadData == e.data);
        if (!ok) begin
          bad++;
          $display("FAIL txn%0d: got ld=%b st=%b data=%h want store=%b data=%h",
                   e.tag, loadDataValid, storeComplete, loadData, e.is_store, e.data);
        end else begin
          $display("txn%0d %s ok data=%h", e.tag, e.is_store ? "store" : "load", loadData);
        end
      end
    end
  end

  initial begin
    int guard;
    reset = 1'b0; address = '0; storeData = '0; byteEnable = '0; storeValid = 1'b0; loadValid = 1'b0;
    repeat (3) tick();
    chk("rst_loadData", loadData, 0);
    chk("rst_valid", {loadDataValid, storeComplete}, 0);
    chk("rst_irq", interrupt, 0);
    reset = 1'b1;
    model_reset();

    // Free-run 10 clocks then read mtime lo
    repeat (10) tick();
    xact(32'h00, 0, 4'h0, 0, 1);

    // Compare match raises interrupt one cycle after mtime reaches 20
    xact(32'h08, 32'd20, 4'hF, 1, 0);
    xact(32'h0C, 32'd0, 4'hF, 1, 0);
    chk("irq_below_cmp", interrupt, 0);
    guard = 0;
    while (mt(edges) != 64'd20 && guard < 60) begin tick(); guard++; end
    chk("irq_at_match_edge", interrupt, 0);
    tick();
    chk("irq_raised", interrupt, 1);
    issue(32'h0C, 32'd1, 4'hF, 1, 0);
    chk("irq_held_capture", interrupt, 1);
    tick();
    chk("irq_cleared", interrupt, 0);

    // Byte-wise store to mtime lo
    xact(32'h00, 32'h0, 4'hF, 1, 0);
    xact(32'h00, 32'hAABBCCDD, 4'b0010, 1, 0);
    xact(32'h00, 0, 4'h0, 0, 1);
    xact(32'h04, 0, 4'h0, 0, 1);

    // Carry from lo into hi, then full 64-bit wrap
    xact(32'h04, 32'h0, 4'hF, 1, 0);
    xact(32'h00, 32'hFFFF_FFFE, 4'hF, 1, 0);
    xact(32'h00, 0, 4'h0, 0, 1);
    xact(32'h04, 0, 4'h0, 0, 1);
    xact(32'h04, 32'hFFFF_FFFF, 4'hF, 1, 0);
    xact(32'h00, 32'hFFFF_FFFF, 4'hF, 1, 0);
    xact(32'h00, 0, 4'h0, 0, 1);
    xact(32'h04, 0, 4'h0, 0, 1);

    // Store wins over simultaneous load; empty byteEnable is a no-op that completes
    xact(32'h08, 32'h1234_5678, 4'hF, 1, 1);
    xact(32'h08, 32'hDEAD_BEEF, 4'h0, 1, 0);
    xact(32'h08, 0, 4'h0, 0, 1);
    xact(32'h0C, 0, 4'h0, 0, 1);

    // Unmapped and unaligned in-window accesses, out-of-window silence
    xact(32'h14, 0, 4'h0, 0, 1);
    xact(32'h02, 0, 4'h0, 0, 1);
    xact(32'h1C, 32'hFFFF_FFFF, 4'hF, 1, 0);
    address = BASE + 32'h20; loadValid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("no_resp_%0d", i), {loadDataValid, storeComplete}, 0);
    end
    loadValid = 1'b0; address = '0;

    // Reset during the BUSY cycle of an msip store
    begin
      exp_t e;
      e.tag = ntag; e.is_store = 1'b1; e.data = '0;
      ntag++;
      sb.push_back(e);
      address = BASE + 32'h10; storeData = 32'h1; byteEnable = 4'hF; storeValid = 1'b1;
      @(posedge clock);
      #2 reset = 1'b0;
      #1;
      chk("rstmid_valid", {loadDataValid, storeComplete}, 0);
      chk("rstmid_irq", interrupt, 0);
      chk("rstmid_loadData", loadData, 0);
      void'(sb.pop_back());
      address = '0; storeData = '0; byteEnable = '0; storeValid = 1'b0;
      @(negedge clock);
    end
    tick(); tick();
    reset = 1'b1;
    model_reset();
    xact(32'h10, 0, 4'h0, 0, 1);
    xact(32'h08, 0, 4'h0, 0, 1);
    xact(32'h0C, 0, 4'h0, 0, 1);
    xact(32'h00, 0, 4'h0, 0, 1);
    chk("post_rst_irq", interrupt, 0);
    xact(32'h10, 32'hFFFF_FFFF, 4'hF, 1, 0);
    chk("msip_irq", interrupt, 1);
    xact(32'h10, 0, 4'h0, 0, 1);

    tick(); tick();
    chk("scoreboard_drained", 64'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
